// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative 32x32 shift-and-add multiplier for MULT/MULTU into HI/LO
// Optional MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.

module mult_unit_rca #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[WIDTH];

endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0]   ONE_W    = 1;
  localparam logic [2*WIDTH-1:0] ONE_P    = 1;
  localparam logic [CW-1:0]      CNT_ONE  = 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_p;
  logic [WIDTH-1:0]   r_a;
  logic               r_neg;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [PW-1:0]      w_p_step;
  logic [PW-1:0]      w_p_next;
  logic               w_early;
  logic               w_run_end;
  logic [2*WIDTH-1:0] w_result;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
  assign w_mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;

  mult_unit_rca #(.WIDTH(WIDTH)) u_rca (
    .i_a    (r_p[2*WIDTH-1:WIDTH]),
    .i_b    (r_a),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The adder carry lands in the top bit and is shifted into P[2W-1].
  assign w_p_step = r_p[0] ? {1'b0, w_cout, w_sum, r_p[WIDTH-1:1]}
                           : {1'b0, r_p[PW-1:1]};

`ifdef MULT_EARLY_TERM_EN
  localparam logic [CW-1:0] CNT_W = CW'(WIDTH);
  logic [WIDTH-1:0] w_remain_mask;

  // Unconsumed multiplier bits sit in P[WIDTH-1-counter:0].
  assign w_remain_mask = {WIDTH{1'b1}} >> r_cnt;
  assign w_early       = ~|(r_p[WIDTH-1:0] & w_remain_mask);
  assign w_p_next      = w_early ? (r_p >> (CNT_W - r_cnt)) : w_p_step;
`else
  assign w_early       = 1'b0;
  assign w_p_next      = w_p_step;
`endif

  assign w_run_end = w_early || (r_cnt == CNT_LAST);
  assign w_result  = r_neg ? (~r_p[2*WIDTH-1:0] + ONE_P) : r_p[2*WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_run_end) w_next = S_SIGN;
      S_SIGN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_SIGN);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_p    <= '0;
      r_a    <= '0;
      r_neg  <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_a   <= w_mag_a;
            r_p   <= {{(WIDTH+1){1'b0}}, w_mag_b};
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_SIGN: begin
          r_hi   <= w_result[2*WIDTH-1:WIDTH];
          r_lo   <= w_result[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative 32x32 shift-and-add multiplier for MIPS MULT/MULTU; produces the 64-bit product into HI/LO.
- Sits downstream of the 32-bit ripple-carry adder (Bit32FullAdder) and consumes its sum/cout each step as the partial-product accumulator. This is the first sequential consumer of the adder in the execute path.
- One add/shift step per clock, with a start/busy/done handshake to the pipeline control.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH; the step counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- op_a  input  WIDTH  multiplicand; sampled with start
- op_b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted
- done  output  1  one-cycle pulse; hi/lo are valid and updated in the same cycle
- hi  output  WIDTH  upper product half; holds until the next completion
- lo  output  WIDTH  lower product half; holds until the next completion

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0. Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, SIGN.
- IDLE:
  - On a clk edge with start=1, latch the following:
    - neg = is_signed & (op_a[W-1] ^ op_b[W-1])
    - |A|, |B|: magnitudes when is_signed, raw values otherwise
  - Load P[2W:0] = {0, |B|}, set counter=0, move to RUN, set busy=1.
  - start=0: remain in IDLE.
- RUN, one step per cycle:
  - If P[0]=1, upper = P[2W:W] + |A|, using the WIDTH-bit adder (cin=0) with cout forming bit 2W. Otherwise upper is unchanged.
  - Shift P right by 1 and increment the counter.
  - After WIDTH steps, move to SIGN.
- SIGN (one cycle):
  - Result = neg ? (~P[2W-1:0] + 1) : P[2W-1:0].
  - Write hi = result[2W-1:W] and lo = result[W-1:0].
  - Set done=1 for this cycle only, set busy=0, return to IDLE.
- Latency: with start sampled at edge 0, done is high after edge WIDTH+1 (33 for WIDTH=32). Throughput is one operation per WIDTH+2 cycles.
- start while busy is ignored and not queued. start high in the cycle done is high is accepted, because the state is already IDLE.
- Operand changes after acceptance have no effect.
- Magnitude of 0x80000000 is 0x80000000, which fits unsigned in WIDTH bits. No overflow is flagged, since the full 2W product is always exact.
- done and busy are never high together. busy is low in IDLE.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, if the not-yet-consumed multiplier bits of P are all zero, then in that cycle:
  - Shift P right by the remaining step count (WIDTH - counter).
  - Move directly to SIGN.
  - Resulting latency is counter+2 cycles, minimum 2 when op_b=0.
  - Results are bit-identical to the full run.
- Not defined: always run exactly WIDTH RUN cycles; latency is fixed at WIDTH+1.

Test Plan:
- Reset, then MULTU 7*6 (start one cycle) -> busy high for 33 cycles, done pulses once at cycle 33, hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. The cout of the final add must be retained in the accumulator.
- Signed cases:
  - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1
  - MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000
  - MULT -1*-1 -> hi=0, lo=1
- start pulsed again at cycle 10 of a run with different operands -> ignored; first result unchanged; hi/lo stable until that done. Back-to-back start on the done cycle -> second result done exactly 33 cycles later.
- Assert reset at cycle 15 of a run -> busy, done, hi, lo go to 0 immediately (asynchronously); no done afterwards. A fresh start after release -> correct result.
- With MULT_EARLY_TERM_EN:
  - MULTU 0x12345678*0 -> done at cycle 2, hi=lo=0
  - MULTU 5*3 -> done at cycle 4, lo=0x0000000F
  - Without the macro, both cases complete at cycle 33.
